masked_sbox_array: RTL and testbench

Parametrised, pipelined, first-order masked AES S-box array: LANES independent byte lanes, each wrapping one 3-cycle two-share masked GF(256) inverter with share-wise affine pre/post-processing. Adds valid/ready flow control, a per-transaction forward/inverse mode, randomness-starvation tracking and in-flight occupancy accounting. Sits between the masked state register and MixColumns in the masked AES datapath.

---
 rtl/masked_sbox_array.sv | 196 +++++++++++++++++++
 tb/tb_masked_sbox_array.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_array.sv
`default_nettype none
// ============================================================================
// Module   : masked_sbox_array
// Purpose  : LANES parallel first-order (two-share) masked AES S-boxes.
//            Each lane applies a share-wise pre-affine step for the inverse
//            S-box. It then runs a pipelined masked GF(256) inverter that
//            computes x^254 with four domain-oriented multiplications. The
//            forward S-box is completed by a share-wise post-affine step.
//            A sideband pipe carries valid/mode/err next to the lane data.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_mode, in_share0/in_share1 (8*LANES)
//            rand_in (RAND_PER_LANE*LANES), rand_valid
//            out_valid/out_mode/out_err, out_share0/out_share1 (8*LANES)
//            occupancy (items in flight), idle
// Revision : 1.0 - initial release
// ============================================================================
module masked_sbox_array #(
  parameter int LANES         = 4,
  parameter int RAND_PER_LANE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_mode,
  input  logic [8*LANES-1:0]             in_share0,
  input  logic [8*LANES-1:0]             in_share1,
  input  logic [RAND_PER_LANE*LANES-1:0] rand_in,
  input  logic                           rand_valid,
  output logic                           out_valid,
  output logic                           out_mode,
  output logic                           out_err,
  output logic [8*LANES-1:0]             out_share0,
  output logic [8*LANES-1:0]             out_share1,
  output logic [2:0]                     occupancy,
  output logic                           idle
);

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Squaring is linear over GF(2), so it is applied to each share separately
  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // Two-share domain-oriented multiply; the fresh byte r hides the cross
  // terms before they join the other domain. Returns {z1, z0}.
  function automatic logic [15:0] dom_mul(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] r);
    logic [7:0] z0;
    logic [7:0] z1;
    z0 = gf_mul(a0, b0) ^ (gf_mul(a0, b1) ^ r);
    z1 = gf_mul(a1, b1) ^ (gf_mul(a1, b0) ^ r);
    return {z1, z0};
  endfunction

  // Linear part of the inverse affine map: rotl1 ^ rotl3 ^ rotl6
  function automatic logic [7:0] lin_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
  endfunction

  // Linear part of the forward affine map: y ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4
  function automatic logic [7:0] lin_fwd(input logic [7:0] y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]};
  endfunction

  // --------------------------------------------------------------------------
  // Sideband pipe: index 0 is the input register, 1..3 are the inverter stages
  // --------------------------------------------------------------------------
  logic       accept;
  logic [3:0] v_q, v_d;
  logic [3:0] m_q, m_d;
  logic [3:0] e_q, e_d;
  logic       out_valid_d, out_mode_d, out_err_d;
  logic [2:0] occ_q, occ_d;

  assign in_ready = rand_valid;
  assign accept   = in_valid & rand_valid;

  always_comb begin
    v_d         = {v_q[2:0], accept};
    m_d         = {m_q[2:0], in_mode};
    // Any valid item alive during a cycle without fresh randomness is marked
    e_d         = {e_q[2:0] | (v_q[2:0] & {3{~rand_valid}}), 1'b0};
    out_valid_d = v_q[3];
    out_mode_d  = m_q[3];
    out_err_d   = e_q[3] | (v_q[3] & ~rand_valid);
    // An item leaves the count when it moves into the output register
    occ_d       = occ_q + {2'b00, accept} - {2'b00, v_q[3]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      m_q       <= '0;
      e_q       <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_err   <= 1'b0;
      occ_q     <= '0;
    end else begin
      v_q       <= v_d;
      m_q       <= m_d;
      e_q       <= e_d;
      out_valid <= out_valid_d;
      out_mode  <= out_mode_d;
      out_err   <= out_err_d;
      occ_q     <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign idle      = (occ_q == 3'd0) && !in_valid;

  // --------------------------------------------------------------------------
  // Per-lane datapath: x^254 = (x^15)^16 * x^14, x^15 = x^12*x^3, x^14 = x^12*x^2
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] rnd;
    logic [7:0]  in0_q, in1_q, in0_d, in1_d;   // affine-adjusted input shares
    logic [7:0]  c0_q, c1_q, c0_d, c1_d;       // x^3
    logic [7:0]  s0_q, s1_q, s0_d, s1_d;       // x^2
    logic [7:0]  u0_q, u1_q, u0_d, u1_d;       // x^15
    logic [7:0]  t0_q, t1_q, t0_d, t1_d;       // x^14
    logic [7:0]  y0_q, y1_q, y0_d, y1_d;       // x^254 (inverse)
    logic [7:0]  o0_q, o1_q, o0_d, o1_d;       // output shares
    logic [7:0]  q0, q1, w0, w1;

    assign rnd = rand_in[RAND_PER_LANE*i +: 32];

    always_comb begin
      // Constant goes into share0 only; share1 sees just the linear map
      if (in_mode) begin
        in0_d = lin_inv(in_share0[8*i +: 8]) ^ 8'h05;
        in1_d = lin_inv(in_share1[8*i +: 8]);
      end else begin
        in0_d = in_share0[8*i +: 8];
        in1_d = in_share1[8*i +: 8];
      end
      s0_d = gf_sq(in0_q);
      s1_d = gf_sq(in1_q);
      {c1_d, c0_d} = dom_mul(in0_q, in1_q, s0_d, s1_d, rnd[7:0]);
      q0 = gf_sq(gf_sq(c0_q));
      q1 = gf_sq(gf_sq(c1_q));
      {u1_d, u0_d} = dom_mul(q0, q1, c0_q, c1_q, rnd[15:8]);
      {t1_d, t0_d} = dom_mul(q0, q1, s0_q, s1_q, rnd[23:16]);
      w0 = gf_sq(gf_sq(gf_sq(gf_sq(u0_q))));
      w1 = gf_sq(gf_sq(gf_sq(gf_sq(u1_q))));
      {y1_d, y0_d} = dom_mul(w0, w1, t0_q, t1_q, rnd[31:24]);
      if (!m_q[3]) begin
        o0_d = lin_fwd(y0_q) ^ 8'h63;
        o1_d = lin_fwd(y1_q);
      end else begin
        o0_d = y0_q;
        o1_d = y1_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in0_q <= '0; in1_q <= '0;
        c0_q  <= '0; c1_q  <= '0;
        s0_q  <= '0; s1_q  <= '0;
        u0_q  <= '0; u1_q  <= '0;
        t0_q  <= '0; t1_q  <= '0;
        y0_q  <= '0; y1_q  <= '0;
        o0_q  <= '0; o1_q  <= '0;
      end else begin
        in0_q <= in0_d; in1_q <= in1_d;
        c0_q  <= c0_d;  c1_q  <= c1_d;
        s0_q  <= s0_d;  s1_q  <= s1_d;
        u0_q  <= u0_d;  u1_q  <= u1_d;
        t0_q  <= t0_d;  t1_q  <= t1_d;
        y0_q  <= y0_d;  y1_q  <= y1_d;
        o0_q  <= o0_d;  o1_q  <= o1_d;
      end
    end

    assign out_share0[8*i +: 8] = o0_q;
    assign out_share1[8*i +: 8] = o1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_masked_sbox_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_sbox_array
// Purpose  : Self-checking bench for masked_sbox_array (LANES = 4). The
//            reference S-box tables are built from log/antilog arithmetic and
//            the affine bit rule; a scoreboard tracks items by accept cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_sbox_array;
  localparam int LANES = 4;
  localparam int RPL   = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid, in_ready, in_mode;
  logic [8*LANES-1:0]     in_share0, in_share1;
  logic [RPL*LANES-1:0]   rand_in;
  logic                   rand_valid;
  logic                   out_valid, out_mode, out_err;
  logic [8*LANES-1:0]     out_share0, out_share1;
  logic [2:0]             occupancy;
  logic                   idle;

  masked_sbox_array #(.LANES(LANES), .RAND_PER_LANE(RPL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_share0(in_share0), .in_share1(in_share1),
    .rand_in(rand_in), .rand_valid(rand_valid),
    .out_valid(out_valid), .out_mode(out_mode), .out_err(out_err),
    .out_share0(out_share0), .out_share1(out_share1),
    .occupancy(occupancy), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference tables ----------------
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  task automatic build_tables();
    int         lg[256];
    logic [7:0] ex[255];
    logic [7:0] e, inv, s, c;
    c = 8'h63;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = e;
      lg[e] = k;
      e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00));  // e * 3
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x]  = s;
      isb[s] = x[7:0];
    end
  endtask

  function automatic logic [31:0] ref_out(input logic m, input logic [31:0] s0, input logic [31:0] s1);
    logic [31:0] r;
    logic [7:0]  x;
    for (int l = 0; l < LANES; l++) begin
      x = s0[8*l +: 8] ^ s1[8*l +: 8];
      r[8*l +: 8] = m ? isb[x] : sb[x];
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] exp;
    logic        mode;
    logic        err;
    int          due;
  } item_t;
  item_t       q[$];
  logic [31:0] s0_log[$];

  initial forever begin
    item_t it;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      foreach (q[j]) if (!rand_valid) q[j].err = 1'b1;
      if (in_valid && in_ready)
        q.push_back('{exp: ref_out(in_mode, in_share0, in_share1), mode: in_mode,
                      err: 1'b0, due: cyc + 4});
    end
    #2;
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
        else begin
          it = q.pop_front();
          chk("latency_cycle", cyc, it.due);
          chk("unmasked_data", out_share0 ^ out_share1, it.exp);
          chk("out_mode", {31'd0, out_mode}, {31'd0, it.mode});
          chk("out_err", {31'd0, out_err}, {31'd0, it.err});
          s0_log.push_back(out_share0);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_out_valid", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      chk("occupancy", {29'd0, occupancy}, q.size());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    rand_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [31:0] data, input logic [31:0] mask);
    in_valid  = 1'b1;
    in_mode   = m;
    in_share0 = data ^ mask;
    in_share1 = mask;
    step();
  endtask

  task automatic idle_n(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] mk;
    build_tables();
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    in_share0 = '0; in_share1 = '0; rand_in = '0; rand_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_occupancy", {29'd0, occupancy}, 32'd0);
    chk("reset_idle", {31'd0, idle}, 32'd1);
    chk("reset_share0", out_share0, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Forward known vectors, checked at edge k+4
    send(1'b0, 32'hFF530100, 32'h81003CA5);
    idle_n(4);
    chk("fwd_vectors", out_share0 ^ out_share1, 32'h16ED7C63);
    chk("fwd_valid", {31'd0, out_valid}, 32'd1);
    idle_n(2);

    // Inverse round trip
    send(1'b1, 32'h16ED7C63, $urandom());
    idle_n(4);
    chk("inv_vectors", out_share0 ^ out_share1, 32'hFF530100);
    chk("inv_mode", {31'd0, out_mode}, 32'd1);
    idle_n(2);

    // Alternating mode every cycle
    for (int i = 0; i < 8; i++) send(i[0], $urandom(), $urandom());
    idle_n(6);

    // 20-item back-to-back stream
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), $urandom(), $urandom());
    idle_n(6);

    // Randomness starvation with 3 items in flight
    for (int i = 0; i < 3; i++) send(1'b0, $urandom(), $urandom());
    rand_valid = 1'b0;
    #1;
    chk("in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    rand_valid = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b0, $urandom(), $urandom());
    idle_n(6);

    // Reset while two items are in flight
    send(1'b0, $urandom(), $urandom());
    send(1'b1, $urandom(), $urandom());
    idle_n(2);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("midrst_idle", {31'd0, idle}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    idle_n(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Mask independence: fixed data, different masks and randomness
    s0_log.delete();
    for (int i = 0; i < 8; i++) begin
      mk = $urandom();
      send(1'b0, 32'h53535353, mk);
    end
    idle_n(6);
    chk("mask_run_count", s0_log.size(), 32'd8);
    for (int a = 0; a < s0_log.size(); a++)
      for (int b = a + 1; b < s0_log.size(); b++)
        chk("share0_varies", {31'd0, s0_log[a] != s0_log[b]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
